acs_unit: RTL and testbench

Add-compare-select unit of the 8-state Viterbi decoder, sitting directly upstream of the survivor-path register exchange. Each enabled cycle it turns one pair of soft channel symbols into branch metrics, updates eight path metrics, and emits the 8-bit decision vector that the survivor path consumes as its `decision`/`data_in` word. It also reports the current best state and keeps the path metrics bounded by MSB-clear normalisation.

---
 rtl/viterbi_pkg.sv | 25 ++
 rtl/acs_node.sv | 26 ++
 rtl/acs_unit.sv | 106 ++++++++++
 tb/tb_acs_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants, types and trellis helpers for the 8-state K=4 Viterbi datapath.
// Pure declarations; no timing.
// Used by the ACS unit, survivor path and traceback logic.
package viterbi_pkg;

  localparam int NB_STATES = 8;
  localparam logic [3:0] G0 = 4'o15;  // taps on {u, s[2], s[1], s[0]}
  localparam logic [3:0] G1 = 4'o17;

  localparam int SOFT_W  = 3;
  localparam int PM_W    = 8;
  localparam int BM_W    = SOFT_W + 1;
  localparam int PM_INIT = 64;

  typedef logic [PM_W-1:0] pm_t;
  typedef logic [BM_W-1:0] bm_t;

  // Encoder output {c0,c1} for input u leaving state s (s[2] is the newest bit).
  function automatic logic [1:0] expected_bits(input logic u, input logic [2:0] state);
    logic [3:0] reg_v;
    reg_v = {u, state};
    return {^(reg_v & G0), ^(reg_v & G1)};
  endfunction

endpackage

// File: rtl/acs_node.sv
// Two-input add-compare-select for one trellis state.
// Purely combinational; no backpressure.
// A tie keeps the even predecessor (decision 0).
module acs_node #(
  parameter int PM_W = 8,
  parameter int BM_W = 4
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [BM_W-1:0] bm0_i,
  input  logic [BM_W-1:0] bm1_i,
  output logic [PM_W-1:0] pm_o,
  output logic            dec_o
);

  logic [PM_W-1:0] cand0, cand1;

  // Metric spread is bounded well below 2^PM_W, so the sums never wrap.
  always_comb begin
    cand0 = pm0_i + {{(PM_W-BM_W){1'b0}}, bm0_i};
    cand1 = pm1_i + {{(PM_W-BM_W){1'b0}}, bm1_i};
    dec_o = (cand1 < cand0);
    pm_o  = dec_o ? cand1 : cand0;
  end

endmodule

// File: rtl/acs_unit.sv
// Eight-state add-compare-select with MSB-clear normalisation and best-state search.
// One cycle from an accepted symbol pair to registered decision/best_state/dec_valid.
// No backpressure: downstream always accepts on dec_valid; start overrides enable.
module acs_unit
  import viterbi_pkg::*;
#(
  parameter int SOFT_W  = viterbi_pkg::SOFT_W,
  parameter int PM_W    = viterbi_pkg::PM_W,
  parameter int PM_INIT = viterbi_pkg::PM_INIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              enable,
  input  logic [SOFT_W-1:0] sym0,
  input  logic [SOFT_W-1:0] sym1,
  output logic [7:0]        decision,
  output logic              dec_valid,
  output logic [2:0]        best_state
);

  localparam int BM_LW = SOFT_W + 1;
  localparam logic [PM_W-1:0] INIT_PM = PM_W'(PM_INIT);

  logic [PM_W-1:0]  pm_q   [NB_STATES];
  logic [PM_W-1:0]  pm_d   [NB_STATES];
  logic [PM_W-1:0]  sel_pm [NB_STATES];
  logic [BM_LW-1:0] bm_c   [4];          // indexed by expected {c0,c1}
  logic [7:0]       dec_w;
  logic [7:0]       decision_q;
  logic             dec_valid_q;
  logic [2:0]       best_q, best_d;
  logic [PM_W-1:0]  best_pm;
  logic [7:0]       msb_v;
  logic             norm;

  // Branch metric for each of the four possible expected code pairs.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      logic [SOFT_W-1:0] d0, d1;
      d0 = c[1] ? ~sym0 : sym0;  // distance to a '1' is max - sym
      d1 = c[0] ? ~sym1 : sym1;
      bm_c[c] = {1'b0, d0} + {1'b0, d1};
    end
  end

  for (genvar n = 0; n < NB_STATES; n++) begin : g_node
    localparam logic [2:0] NS = 3'(n);
    localparam logic [2:0] P0 = {NS[1:0], 1'b0};
    localparam logic [2:0] P1 = {NS[1:0], 1'b1};
    localparam logic [1:0] C0 = expected_bits(NS[2], P0);
    localparam logic [1:0] C1 = expected_bits(NS[2], P1);

    acs_node #(.PM_W(PM_W), .BM_W(BM_LW)) u_node (
      .pm0_i (pm_q[P0]),
      .pm1_i (pm_q[P1]),
      .bm0_i (bm_c[C0]),
      .bm1_i (bm_c[C1]),
      .pm_o  (sel_pm[n]),
      .dec_o (dec_w[n])
    );
  end

  // Clear the MSB everywhere once every survivor has it set; then find the lowest-index minimum.
  always_comb begin
    for (int n = 0; n < NB_STATES; n++) msb_v[n] = sel_pm[n][PM_W-1];
    norm = &msb_v;
    for (int n = 0; n < NB_STATES; n++) begin
      pm_d[n] = sel_pm[n];
      if (norm) pm_d[n][PM_W-1] = 1'b0;
    end
    best_d  = '0;
    best_pm = pm_d[0];
    for (int n = 1; n < NB_STATES; n++) begin
      if (pm_d[n] < best_pm) begin
        best_pm = pm_d[n];
        best_d  = 3'(n);
      end
    end
  end

  // Metric and output registers; start reloads metrics but leaves decision/best_state alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NB_STATES; n++) pm_q[n] <= (n == 0) ? '0 : INIT_PM;
      decision_q  <= '0;
      best_q      <= '0;
      dec_valid_q <= 1'b0;
    end else if (start) begin
      for (int n = 0; n < NB_STATES; n++) pm_q[n] <= (n == 0) ? '0 : INIT_PM;
      dec_valid_q <= 1'b0;
    end else if (enable) begin
      for (int n = 0; n < NB_STATES; n++) pm_q[n] <= pm_d[n];
      decision_q  <= dec_w;
      best_q      <= best_d;
      dec_valid_q <= 1'b1;
    end else begin
      dec_valid_q <= 1'b0;
    end
  end

  assign decision   = decision_q;
  assign dec_valid  = dec_valid_q;
  assign best_state = best_q;

endmodule

// File: tb/tb_acs_unit.sv
module tb_acs_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       enable;
  logic [2:0] sym0, sym1;
  logic [7:0] decision;
  logic       dec_valid;
  logic [2:0] best_state;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int   m_pm [8];
  int   m_dec;
  int   m_best;
  int   m_valid;
  int   norm_cnt = 0;

  acs_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .enable     (enable),
    .sym0       (sym0),
    .sym1       (sym1),
    .decision   (decision),
    .dec_valid  (dec_valid),
    .best_state (best_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int parity4(input int x);
    return $countones(x[3:0]) & 1;
  endfunction

  task automatic model_load_init();
    m_pm[0] = 0;
    for (int i = 1; i < 8; i++) m_pm[i] = 64;
  endtask

  // Forward trellis walk: every (state, input) branch offers a candidate to its successor.
  task automatic model_step(input int a, input int b);
    int newpm [8];
    int dec;
    bit all_hi;
    for (int i = 0; i < 8; i++) newpm[i] = 1 << 30;
    dec = 0;
    for (int s = 0; s < 8; s++) begin
      for (int u = 0; u < 2; u++) begin
        int r, c0, c1, bm, ns, cand;
        r    = (u << 3) | s;
        c0   = parity4(r & 'o15);
        c1   = parity4(r & 'o17);
        bm   = (c0 ? 7 - a : a) + (c1 ? 7 - b : b);
        ns   = (u << 2) | (s >> 1);
        cand = m_pm[s] + bm;
        // even predecessor is visited first, so strict < keeps it on ties
        if (cand < newpm[ns]) begin
          newpm[ns] = cand;
          if (s % 2 == 1) dec = dec | (1 << ns);
          else            dec = dec & ~(1 << ns);
        end
      end
    end
    all_hi = 1'b1;
    for (int i = 0; i < 8; i++) if (newpm[i] < 128) all_hi = 1'b0;
    if (all_hi) begin
      norm_cnt++;
      for (int i = 0; i < 8; i++) newpm[i] -= 128;
    end
    m_best = 0;
    for (int i = 1; i < 8; i++) if (newpm[i] < newpm[m_best]) m_best = i;
    for (int i = 0; i < 8; i++) m_pm[i] = newpm[i];
    m_dec = dec;
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic cycle(input bit st, input bit en, input int a, input int b);
    @(negedge clk);
    start  = st;
    enable = en;
    sym0   = 3'(a);
    sym1   = 3'(b);
    @(posedge clk);
    #1;
    if (st) begin
      model_load_init();
      m_valid = 0;
    end else if (en) begin
      model_step(a, b);
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " dec_valid"}, int'(dec_valid), m_valid);
    chk({tag, " decision"}, int'(decision), m_dec);
    chk({tag, " best_state"}, int'(best_state), m_best);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s pm%0d", tag, i), int'(dut.pm_q[i]), m_pm[i]);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; enable = 1'b0; sym0 = '0; sym1 = '0;
    model_load_init();
    m_dec = 0; m_best = 0; m_valid = 0;
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // single symbol pair (0,0) from reset
    cycle(0, 1, 0, 0);
    check_all("s1");
    chk("s1 pm0 const", int'(dut.pm_q[0]), 0);
    chk("s1 pm4 const", int'(dut.pm_q[4]), 14);
    chk("s1 best const", int'(best_state), 0);
    chk("s1 valid const", int'(dec_valid), 1);
    cycle(0, 0, 0, 0);
    check_all("s1 idle");
    chk("s1 valid drop", int'(dec_valid), 0);

    // short clean-ish path 1,0,1 after a restart
    cycle(1, 0, 0, 0);
    check_all("s2 start");
    cycle(0, 1, 7, 7); check_all("s2 a");
    cycle(0, 1, 0, 7); check_all("s2 b");
    cycle(0, 1, 7, 0); check_all("s2 c");

    // tie case: equal candidates must keep the even predecessor
    cycle(1, 0, 0, 0);
    cycle(0, 1, 3, 4); check_all("tie");

    // random soft pairs, ~50% enable duty
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 200; k++) begin
      cycle(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      check_all($sformatf("rnd%0d", k));
    end
    chk("norm fired", int'(norm_cnt > 0), 1);

    // start together with enable mid-frame
    for (int k = 0; k < 4; k++) cycle(0, 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    check_all("pre-start");
    cycle(1, 1, 7, 7);
    check_all("start+en");

    // asynchronous reset in the middle of a burst
    cycle(0, 1, 2, 5);
    cycle(0, 1, 6, 1);
    @(negedge clk);
    enable = 1'b1; sym0 = 3'd4; sym1 = 3'd4;
    #2;
    rst = 1'b0;
    #1;
    model_load_init();
    m_dec = 0; m_best = 0; m_valid = 0;
    check_all("async rst");
    @(posedge clk); #1;
    check_all("rst held");
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    cycle(0, 1, 0, 0);
    check_all("post rst");
    chk("post rst pm4", int'(dut.pm_q[4]), 14);
    chk("post rst pm0", int'(dut.pm_q[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
